// File: rtl/main_memory.sv
// ---------------------------------------------------------------------------
// main_memory
//
// Line-granular backing store for the data cache. A single line-fill read can
// be outstanding at a time and is answered a fixed LATENCY cycles after it is
// accepted; line write-backs are accepted on every cycle and never stall.
//
// Ports
//   clk             : single clock, all state changes on the rising edge
//   rst             : synchronous, active-high reset (does not clear storage)
//   mem_req         : line-fill read request
//   mem_req_addr    : read address (offset bits ignored)
//   mem_write       : line write-back strobe
//   mem_write_addr  : write address (offset bits ignored)
//   mem_write_data  : line to write
//   mem_res         : one-cycle read response pulse
//   mem_res_addr    : line-aligned address of the response (0 when idle)
//   mem_res_data    : response line (0 when idle)
//
// Handshake: mem_req acts as a valid with an implicit ready that is high only
// while the FSM is IDLE; a request presented while BUSY is simply not taken
// and must be held (or re-presented) until IDLE. mem_res is a valid-only
// pulse with no back-pressure: the cache must consume it in that cycle.
// mem_write has no ready at all; every strobed write lands at that edge.
// ---------------------------------------------------------------------------

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

`ifndef CACHE_LINE_SIZE
`define CACHE_LINE_SIZE 128
`endif

module main_memory #(
    parameter int WORD_SIZE = `WORD_SIZE,
    parameter int LINE_SIZE = `CACHE_LINE_SIZE,
    parameter int MEM_LINES = 4096,
    parameter int LATENCY   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_req,
    input  logic [WORD_SIZE-1:0] mem_req_addr,
    input  logic                 mem_write,
    input  logic [WORD_SIZE-1:0] mem_write_addr,
    input  logic [LINE_SIZE-1:0] mem_write_data,
    output logic                 mem_res,
    output logic [WORD_SIZE-1:0] mem_res_addr,
    output logic [LINE_SIZE-1:0] mem_res_data
);

    // Byte offset inside a line, and the slice of the address that selects
    // a storage line. Bits above the index are dropped, so high addresses
    // alias onto the array.
    localparam int OFFSET_W = $clog2(LINE_SIZE / 8);
    localparam int INDEX_W  = $clog2(MEM_LINES);
    localparam int CNT_W    = $clog2(LATENCY + 1);

    localparam logic [CNT_W-1:0]     CNT_LOAD    = CNT_W'(LATENCY - 1);
    localparam logic [WORD_SIZE-1:0] OFFSET_MASK =
        {{(WORD_SIZE - OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_next;
    logic [WORD_SIZE-1:0] line_addr;
    logic [WORD_SIZE-1:0] line_addr_next;
    logic                 resp;

    logic [LINE_SIZE-1:0] mem [MEM_LINES];

    logic [INDEX_W-1:0]   read_index;
    logic [INDEX_W-1:0]   write_index;
    logic                 bypass;

    // Only the index slice of the write address is meaningful.
    logic                 unused_write_addr;
    assign unused_write_addr = ^mem_write_addr;

    assign read_index  = line_addr[OFFSET_W +: INDEX_W];
    assign write_index = mem_write_addr[OFFSET_W +: INDEX_W];

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            line_addr <= '0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            line_addr <= line_addr_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state / response strobe
    // The counter is loaded with LATENCY-1 on acceptance; the response
    // cycle is the BUSY cycle in which it has reached zero, and the FSM
    // returns to IDLE on the following edge. That extra IDLE cycle is what
    // keeps a continuously held mem_req from producing back-to-back pulses.
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state;
        count_next     = count;
        line_addr_next = line_addr;
        resp           = 1'b0;

        case (state)
            IDLE: begin
                if (mem_req) begin
                    line_addr_next = mem_req_addr & OFFSET_MASK;
                    count_next     = CNT_LOAD;
                    state_next     = BUSY;
                end
            end

            BUSY: begin
                if (count != '0) begin
                    count_next = count - CNT_W'(1);
                end else begin
                    resp       = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage. Not reset: contents survive rst, and a write strobed during
    // a reset cycle still lands.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_write) begin
            mem[write_index] <= mem_write_data;
        end
    end

    // A write to the responding line in the response cycle has not landed
    // yet, so forward it straight to the response.
    assign bypass = mem_write && (write_index == read_index);

    // ------------------------------------------------------------------
    // Response outputs, forced to zero outside the response cycle
    // ------------------------------------------------------------------
    assign mem_res      = resp;
    assign mem_res_addr = resp ? line_addr : '0;
    assign mem_res_data = resp ? (bypass ? mem_write_data : mem[read_index]) : '0;

endmodule

// File: tb/tb_main_memory.sv
// ---------------------------------------------------------------------------
// tb_main_memory
//
// Two instances share one set of inputs: dut0 with the default LATENCY=5 and
// 4096 lines, dut1 with LATENCY=1 and 16 lines. A reference model tracks, per
// instance, the edge at which a read was accepted and the absolute cycle in
// which its response is due, plus a sparse line store. Every cycle both
// instances' response outputs are compared against the model.
// ---------------------------------------------------------------------------

module tb_main_memory;

    localparam int L0  = 5;
    localparam int L1  = 1;
    localparam int ML0 = 4096;
    localparam int ML1 = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         mem_req;
    logic [31:0]  mem_req_addr;
    logic         mem_write;
    logic [31:0]  mem_write_addr;
    logic [127:0] mem_write_data;

    logic         res0;
    logic [31:0]  res_addr0;
    logic [127:0] res_data0;
    logic         res1;
    logic [31:0]  res_addr1;
    logic [127:0] res_data1;

    main_memory #(
        .WORD_SIZE (32),
        .LINE_SIZE (128),
        .MEM_LINES (ML0),
        .LATENCY   (L0)
    ) dut0 (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_req_addr   (mem_req_addr),
        .mem_write      (mem_write),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .mem_res        (res0),
        .mem_res_addr   (res_addr0),
        .mem_res_data   (res_data0)
    );

    main_memory #(
        .WORD_SIZE (32),
        .LINE_SIZE (128),
        .MEM_LINES (ML1),
        .LATENCY   (L1)
    ) dut1 (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_req_addr   (mem_req_addr),
        .mem_write      (mem_write),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .mem_res        (res1),
        .mem_res_addr   (res_addr1),
        .mem_res_data   (res_data1)
    );

    // ---------------- reference model ----------------
    int           errors = 0;
    int           checks = 0;
    int           cycle_n = 0;    // number of rising edges seen so far
    bit           check_en = 1'b0;
    bit           pend [2];
    int           resp_cyc [2];
    logic [31:0]  raddr [2];
    logic [127:0] mem_m0 [int];
    logic [127:0] mem_m1 [int];

    function automatic int lat_of(input int i);
        return (i == 0) ? L0 : L1;
    endfunction

    function automatic int line_of(input int i, input logic [31:0] a);
        logic [31:0] l;
        l = a >> 4;
        return (i == 0) ? int'(l % ML0) : int'(l % ML1);
    endfunction

    function automatic logic [127:0] mem_get(input int i, input int idx);
        if (i == 0) return mem_m0.exists(idx) ? mem_m0[idx] : 'x;
        return mem_m1.exists(idx) ? mem_m1[idx] : 'x;
    endfunction

    // ---------------- scoreboard compare ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            logic         exp_res;
            logic         obs_res;
            logic [31:0]  obs_addr;
            logic [127:0] obs_data;
            logic [127:0] exp_data;
            int           idx;
            exp_res  = pend[i] && (cycle_n == resp_cyc[i]);
            obs_res  = (i == 0) ? res0 : res1;
            obs_addr = (i == 0) ? res_addr0 : res_addr1;
            obs_data = (i == 0) ? res_data0 : res_data1;
            check($sformatf("dut%0d_res_c%0d", i, cycle_n), {127'b0, obs_res}, {127'b0, exp_res});
            if (exp_res) begin
                idx = line_of(i, raddr[i]);
                exp_data = (mem_write && line_of(i, mem_write_addr) == idx) ? mem_write_data
                                                                            : mem_get(i, idx);
                check($sformatf("dut%0d_addr_c%0d", i, cycle_n), {96'b0, obs_addr}, {96'b0, raddr[i]});
                check($sformatf("dut%0d_data_c%0d", i, cycle_n), obs_data, exp_data);
            end else begin
                check($sformatf("dut%0d_idle_addr_c%0d", i, cycle_n), {96'b0, obs_addr}, 128'b0);
                check($sformatf("dut%0d_idle_data_c%0d", i, cycle_n), obs_data, 128'b0);
            end
        end
    endtask

    // Apply the rules of one rising edge to the model.
    task automatic model_edge();
        int e;
        e = cycle_n + 1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                pend[i] = 1'b0;
            end else if (pend[i] && cycle_n == resp_cyc[i]) begin
                pend[i] = 1'b0;
            end else if (!pend[i] && mem_req) begin
                pend[i]     = 1'b1;
                resp_cyc[i] = e + lat_of(i) - 1;
                raddr[i]    = mem_req_addr & 32'hFFFF_FFF0;
            end
        end
        if (mem_write) begin
            mem_m0[line_of(0, mem_write_addr)] = mem_write_data;
            mem_m1[line_of(1, mem_write_addr)] = mem_write_data;
        end
        if (rst) check_en = 1'b1;
        cycle_n = e;
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge: drive, check mid-cycle, cross the rising edge.
    task automatic step(input logic r, input logic q, input logic [31:0] ra,
                        input logic w, input logic [31:0] wa, input logic [127:0] wd);
        rst            = r;
        mem_req        = q;
        mem_req_addr   = ra;
        mem_write      = w;
        mem_write_addr = wa;
        mem_write_data = wd;
        #1;
        if (check_en) check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 128'h0);
    endtask

    task automatic wr(input logic [31:0] wa, input logic [127:0] wd);
        step(1'b0, 1'b0, 32'h0, 1'b1, wa, wd);
    endtask

    task automatic rd(input logic [31:0] ra);
        step(1'b0, 1'b1, ra, 1'b0, 32'h0, 128'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst            = 1'b0;
        mem_req        = 1'b0;
        mem_req_addr   = '0;
        mem_write      = 1'b0;
        mem_write_addr = '0;
        mem_write_data = '0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        resp_cyc[0] = -1;
        resp_cyc[1] = -1;
        raddr[0] = '0;
        raddr[1] = '0;
        @(negedge clk);

        // Reset, then quiet cycles: outputs must be all zero.
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 128'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 128'h0);
        idle(2);

        // Fill the lines used by random traffic.
        for (int l = 0; l < 32; l++) begin
            wr(32'(l) << 4, {$urandom, $urandom, $urandom, $urandom});
        end

        // Write AA pattern at 0x100, read through 0x104.
        wr(32'h0000_0100, {16{8'hAA}});
        rd(32'h0000_0104);
        idle(7);

        // Request held high continuously.
        wr(32'h0000_0200, {4{32'h1234_5678}});
        for (int k = 0; k < 20; k++) rd(32'h0000_0200);
        idle(6);

        // Write landing while the read is pending, then a write in the
        // response cycle itself (bypass).
        wr(32'h0000_0300, {16{8'h11}});
        rd(32'h0000_0300);
        idle(1);
        wr(32'h0000_0300, {16{8'h55}});
        idle(4);
        rd(32'h0000_0300);
        idle(4);
        wr(32'h0000_0300, {16{8'h77}});
        idle(2);

        // Read aborted by reset, then a normal read.
        wr(32'h0000_0400, {4{32'hCAFE_F00D}});
        rd(32'h0000_0400);
        idle(2);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 128'h0);
        idle(20);
        rd(32'h0000_0400);
        idle(6);

        // Write during reset still lands.
        step(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0410, {4{32'h0BAD_BEEF}});
        rd(32'h0000_0410);
        idle(6);

        // Aliasing: 0x10000 and 0x00000 map to the same line.
        wr(32'h0001_0000, {4{32'hA1A1_A1A1}});
        rd(32'h0000_0000);
        idle(6);
        wr(32'h0000_0000, {4{32'hB2B2_B2B2}});
        rd(32'h0001_0000);
        idle(6);

        // Simultaneous write and request to the same line.
        step(1'b0, 1'b1, 32'h0000_0050, 1'b1, 32'h0000_0058, {4{32'h5EED_0001}});
        idle(6);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            logic        r;
            logic        q;
            logic        w;
            logic [31:0] ra;
            logic [31:0] wa;
            r  = ($urandom_range(0, 49) == 0);
            q  = ($urandom_range(0, 1) == 1);
            w  = ($urandom_range(0, 9) < 4);
            ra = (32'($urandom_range(0, 65535)) << 16) | (32'($urandom_range(0, 31)) << 4)
                 | 32'($urandom_range(0, 15));
            wa = (32'($urandom_range(0, 65535)) << 16) | (32'($urandom_range(0, 31)) << 4)
                 | 32'($urandom_range(0, 15));
            step(r, q, ra, w, wa, {$urandom, $urandom, $urandom, $urandom});
        end
        idle(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
